// File: rtl/isa_io_target_if.sv
// ISA pin-side and HPS-side signal bundle for the isa_io_target I/O responder.
// slave = the responder itself; master = the riser pins plus the HPS bridge.
interface isa_io_target_if #(
    parameter int unsigned WINDOW_BITS = 4
);
    logic [15:0]            address_bus;
    logic [15:0]            data_bus_in;
    logic                   IOW;
    logic                   IOR;
    logic [15:0]            data_bus_out;
    logic                   data_bus_oe;
    logic                   wr_valid;
    logic                   wr_ready;
    logic [WINDOW_BITS-1:0] wr_port;
    logic [15:0]            wr_data;
    logic                   rb_we;
    logic [WINDOW_BITS-1:0] rb_addr;
    logic [15:0]            rb_data;
    logic                   rd_strobe;
    logic [WINDOW_BITS-1:0] rd_port;
    logic                   overflow;
    logic                   overflow_clear;

    modport slave (
        input  address_bus, data_bus_in, IOW, IOR, wr_ready,
               rb_we, rb_addr, rb_data, overflow_clear,
        output data_bus_out, data_bus_oe, wr_valid, wr_port, wr_data,
               rd_strobe, rd_port, overflow
    );

    modport master (
        output address_bus, data_bus_in, IOW, IOR, wr_ready,
               rb_we, rb_addr, rb_data, overflow_clear,
        input  data_bus_out, data_bus_oe, wr_valid, wr_port, wr_data,
               rd_strobe, rd_port, overflow
    );
endinterface

// File: rtl/isa_io_target.sv
// ISA I/O-port target: decodes a port window, queues bus writes for the HPS
// in a FWFT FIFO and answers bus reads from an HPS-loaded readback file.
module isa_io_target #(
    parameter logic [15:0] BASE_ADDR       = 16'h0220,
    parameter int unsigned WINDOW_BITS     = 4,
    parameter int unsigned FIFO_DEPTH_LOG2 = 3
) (
    input logic            clk,
    input logic            reset,
    isa_io_target_if.slave bus
);
    localparam int unsigned NPORTS = 1 << WINDOW_BITS;
    localparam int unsigned DEPTH  = 1 << FIFO_DEPTH_LOG2;

    typedef logic [WINDOW_BITS-1:0]   port_t;
    typedef logic [FIFO_DEPTH_LOG2:0] ptr_t;
    typedef struct packed {
        port_t       port;
        logic [15:0] data;
    } entry_t;
    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    localparam ptr_t PTR_ONE = ptr_t'(1);

    state_t      state_q, state_d;
    port_t       port_q, port_d;
    port_t       rd_port_q, rd_port_d;
    logic [15:0] dout_q, dout_d;
    logic [15:0] data_q;
    logic        oe_q, oe_d;
    logic        rd_strobe_q, rd_strobe_d;
    logic        push;

    logic iow_s1, iow_s, ior_s1, ior_s;

    logic [15:0] rb_regs [NPORTS];

    entry_t mem [DEPTH];
    ptr_t   wptr, rptr, rptr_inc;
    entry_t head_q;
    logic   head_valid;
    logic   full, empty, pop, push_ok;
    logic   overflow_q;

    logic  hit;
    port_t addr_port;

    // Strobes are asynchronous to clk; idle (high) out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            iow_s1 <= 1'b1;
            iow_s  <= 1'b1;
            ior_s1 <= 1'b1;
            ior_s  <= 1'b1;
        end else begin
            iow_s1 <= bus.IOW;
            iow_s  <= iow_s1;
            ior_s1 <= bus.IOR;
            ior_s  <= ior_s1;
        end
    end

    assign hit       = bus.address_bus[15:WINDOW_BITS] == BASE_ADDR[15:WINDOW_BITS];
    assign addr_port = bus.address_bus[WINDOW_BITS-1:0];

    always_comb begin
        state_d     = state_q;
        port_d      = port_q;
        rd_port_d   = rd_port_q;
        dout_d      = dout_q;
        oe_d        = oe_q;
        rd_strobe_d = 1'b0;
        push        = 1'b0;
        case (state_q)
            IDLE: begin
                if (!iow_s && hit) begin
                    state_d = WRITE;
                    port_d  = addr_port;
                end else if (!ior_s && hit) begin
                    state_d     = READ;
                    port_d      = addr_port;
                    rd_port_d   = addr_port;
                    dout_d      = rb_regs[addr_port];
                    oe_d        = 1'b1;
                    rd_strobe_d = 1'b1;
                end
            end
            WRITE: begin
                if (iow_s) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end
            end
            READ: begin
                if (ior_s) begin
                    oe_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            port_q      <= '0;
            rd_port_q   <= '0;
            dout_q      <= '0;
            oe_q        <= 1'b0;
            rd_strobe_q <= 1'b0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            port_q      <= port_d;
            rd_port_q   <= rd_port_d;
            dout_q      <= dout_d;
            oe_q        <= oe_d;
            rd_strobe_q <= rd_strobe_d;
            if (state_q == WRITE)
                data_q <= bus.data_bus_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NPORTS; i++)
                rb_regs[i] <= '0;
        end else if (bus.rb_we) begin
            rb_regs[bus.rb_addr] <= bus.rb_data;
        end
    end

    // The head entry stays counted in the pointers until popped, so the
    // output register never adds capacity beyond DEPTH.
    assign empty    = wptr == rptr;
    assign full     = (wptr[FIFO_DEPTH_LOG2] != rptr[FIFO_DEPTH_LOG2]) &&
                      (wptr[FIFO_DEPTH_LOG2-1:0] == rptr[FIFO_DEPTH_LOG2-1:0]);
    assign pop      = head_valid && bus.wr_ready;
    assign push_ok  = push && (!full || pop);
    assign rptr_inc = rptr + PTR_ONE;

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wptr[FIFO_DEPTH_LOG2-1:0]] <= '{port: port_q, data: data_q};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr       <= '0;
            rptr       <= '0;
            head_q     <= '0;
            head_valid <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok)
                wptr <= wptr + PTR_ONE;
            if (pop) begin
                rptr <= rptr_inc;
                if (rptr_inc != wptr) begin
                    head_q     <= mem[rptr_inc[FIFO_DEPTH_LOG2-1:0]];
                    head_valid <= 1'b1;
                end else begin
                    head_valid <= 1'b0;
                end
            end else if (!head_valid && !empty) begin
                head_q     <= mem[rptr[FIFO_DEPTH_LOG2-1:0]];
                head_valid <= 1'b1;
            end
            if (push && full && !pop)
                overflow_q <= 1'b1;
            else if (bus.overflow_clear)
                overflow_q <= 1'b0;
        end
    end

    assign bus.data_bus_out = dout_q;
    assign bus.data_bus_oe  = oe_q;
    assign bus.rd_strobe    = rd_strobe_q;
    assign bus.rd_port      = rd_port_q;
    assign bus.wr_valid     = head_valid;
    assign bus.wr_port      = head_q.port;
    assign bus.wr_data      = head_q.data;
    assign bus.overflow     = overflow_q;
endmodule

// File: tb/tb_isa_io_target.sv
// Self-checking bench for isa_io_target: directed flows plus randomized bus
// traffic compared against a queue/array model of the port window.
module tb_isa_io_target;
    logic clk;
    logic reset;

    isa_io_target_if #(.WINDOW_BITS(4)) bus_if ();

    isa_io_target #(
        .BASE_ADDR      (16'h0220),
        .WINDOW_BITS    (4),
        .FIFO_DEPTH_LOG2(3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  port;
        logic [15:0] data;
    } ent_t;

    ent_t        q[$];
    logic [15:0] rb_m [16];
    logic        ovf_m;
    int          rd_cnt;
    int          rd_cnt_start;
    int          n_checks;
    int          n_errors;
    logic        auto_ready;
    logic        man_ready;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit in_win(input logic [15:0] a);
        return a[15:4] == 12'h022;
    endfunction

    // HPS side: drives wr_ready and checks every pop against the model queue.
    initial begin
        bus_if.wr_ready = 1'b0;
        rd_cnt = 0;
        forever begin
            @(negedge clk);
            #1;
            bus_if.wr_ready = auto_ready ? 1'($urandom_range(0, 1)) : man_ready;
            if (reset && bus_if.wr_valid && bus_if.wr_ready) begin
                check("pop_model_nonempty", 32'(q.size() != 0), 32'(bus_if.wr_valid));
                if (q.size() != 0) begin
                    check("pop_port", 32'(bus_if.wr_port), 32'(q[0].port));
                    check("pop_data", 32'(bus_if.wr_data), 32'(q[0].data));
                    void'(q.pop_front());
                end
            end
            if (bus_if.rd_strobe)
                rd_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rb_write(input logic [3:0] a, input logic [15:0] d);
        bus_if.rb_we   = 1'b1;
        bus_if.rb_addr = a;
        bus_if.rb_data = d;
        @(negedge clk);
        bus_if.rb_we = 1'b0;
        rb_m[a] = d;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d, input int hold,
                             input bit chk_lat, input bit pop_at_push);
        int got;
        bus_if.address_bus = a;
        bus_if.data_bus_in = d;
        bus_if.IOW = 1'b0;
        tick(hold);
        bus_if.IOW = 1'b1;
        if (in_win(a)) begin
            if (q.size() < 8 || pop_at_push)
                q.push_back('{port: a[3:0], data: d});
            else
                ovf_m = 1'b1;
        end
        if (chk_lat) begin
            got = 0;
            for (int c = 1; c <= 10; c++) begin
                @(negedge clk);
                if (bus_if.wr_valid) begin
                    got = c;
                    break;
                end
            end
            check("wr_latency", 32'(got), 32'd4);
        end else begin
            tick(2);
            if (pop_at_push)
                man_ready = 1'b1;
            tick(2);
        end
    endtask

    task automatic read_begin(input logic [15:0] a, input logic [15:0] exp_d);
        int got;
        rd_cnt_start = rd_cnt;
        bus_if.address_bus = a;
        bus_if.IOR = 1'b0;
        got = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (bus_if.data_bus_oe) begin
                got = c;
                break;
            end
        end
        check("rd_oe_latency", 32'(got), 32'd3);
        check("rd_data", 32'(bus_if.data_bus_out), 32'(exp_d));
        check("rd_port", 32'(bus_if.rd_port), 32'(a[3:0]));
    endtask

    task automatic read_end();
        int got;
        bus_if.IOR = 1'b1;
        got = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (!bus_if.data_bus_oe) begin
                got = c;
                break;
            end
        end
        check("rd_oe_release", 32'(got), 32'd3);
        check("rd_strobe_count", 32'(rd_cnt - rd_cnt_start), 32'd1);
        tick(1);
    endtask

    task automatic oow_read(input logic [15:0] a);
        logic seen;
        int   c0;
        c0 = rd_cnt;
        seen = 1'b0;
        bus_if.address_bus = a;
        bus_if.IOR = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            seen = seen | bus_if.data_bus_oe;
        end
        bus_if.IOR = 1'b1;
        tick(3);
        check("oow_rd_oe", 32'(seen), 32'd0);
        check("oow_rd_strobe", 32'(rd_cnt - c0), 32'd0);
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 300; c++) begin
            if (q.size() == 0 && !bus_if.wr_valid)
                break;
            @(negedge clk);
        end
        tick(2);
        check("drain_valid", 32'(bus_if.wr_valid), 32'd0);
        check("drain_model_left", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a, d;
        logic [3:0]  p;
        logic        seen;

        n_checks = 0;
        n_errors = 0;
        auto_ready = 1'b0;
        man_ready = 1'b0;
        ovf_m = 1'b0;
        for (int i = 0; i < 16; i++) rb_m[i] = '0;
        reset = 1'b0;
        bus_if.address_bus = '0;
        bus_if.data_bus_in = '0;
        bus_if.IOW = 1'b1;
        bus_if.IOR = 1'b1;
        bus_if.rb_we = 1'b0;
        bus_if.rb_addr = '0;
        bus_if.rb_data = '0;
        bus_if.overflow_clear = 1'b0;

        tick(3);
        check("rst_oe", 32'(bus_if.data_bus_oe), 32'd0);
        check("rst_dout", 32'(bus_if.data_bus_out), 32'd0);
        check("rst_wr_valid", 32'(bus_if.wr_valid), 32'd0);
        check("rst_overflow", 32'(bus_if.overflow), 32'd0);
        check("rst_rd_strobe", 32'(bus_if.rd_strobe), 32'd0);
        check("rst_rd_port", 32'(bus_if.rd_port), 32'd0);
        reset = 1'b1;
        tick(2);

        // Write flow with latency from IOW release to wr_valid
        bus_write(16'h022C, 16'hA55A, 6, 1'b1, 1'b0);
        check("wf_port", 32'(bus_if.wr_port), 32'hC);
        check("wf_data", 32'(bus_if.wr_data), 32'hA55A);
        man_ready = 1'b1;
        tick(1);
        check("wf_pop_clears", 32'(bus_if.wr_valid), 32'd0);
        man_ready = 1'b0;

        // Readback flow
        rb_write(4'd3, 16'h1234);
        read_begin(16'h0223, rb_m[3]);
        tick(2);
        read_end();

        // Out-of-window accesses
        oow_read(16'h0230);
        bus_write(16'h0210, 16'hDEAD, 4, 1'b0, 1'b0);
        check("oow_wr_fifo", 32'(bus_if.wr_valid), 32'd0);

        // FIFO full: ninth write dropped
        for (int i = 1; i <= 9; i++)
            bus_write(16'h0220 + 16'(i & 15), 16'(i), 3, 1'b0, 1'b0);
        tick(2);
        check("full_overflow", 32'(bus_if.overflow), 32'(ovf_m));
        man_ready = 1'b1;
        wait_drain();
        man_ready = 1'b0;
        bus_if.overflow_clear = 1'b1;
        tick(1);
        bus_if.overflow_clear = 1'b0;
        ovf_m = 1'b0;
        check("ovf_cleared", 32'(bus_if.overflow), 32'(ovf_m));

        // Push while full with a simultaneous pop is accepted
        for (int i = 0; i < 8; i++)
            bus_write(16'h0220 + 16'(i), 16'h0100 + 16'(i), 3, 1'b0, 1'b0);
        bus_write(16'h0228, 16'h0200, 3, 1'b0, 1'b1);
        for (int i = 1; i < 8; i++)
            bus_write(16'h0228 + 16'(i), 16'h0200 + 16'(i), 3, 1'b0, 1'b0);
        check("full_pop_no_ovf", 32'(bus_if.overflow), 32'(ovf_m));
        wait_drain();
        man_ready = 1'b0;

        // Snapshot held while readback register changes
        rb_write(4'd5, 16'h00FF);
        read_begin(16'h0225, rb_m[5]);
        rb_write(4'd5, 16'hBEEF);
        check("snap_hold", 32'(bus_if.data_bus_out), 32'h00FF);
        read_end();
        read_begin(16'h0225, rb_m[5]);
        read_end();

        // Reset mid-read
        rb_write(4'd7, 16'h7777);
        read_begin(16'h0227, rb_m[7]);
        #3;
        reset = 1'b0;
        #1;
        check("rst_mid_oe", 32'(bus_if.data_bus_oe), 32'd0);
        check("rst_mid_dout", 32'(bus_if.data_bus_out), 32'd0);
        check("rst_mid_rd_port", 32'(bus_if.rd_port), 32'd0);
        for (int i = 0; i < 16; i++) rb_m[i] = '0;
        q.delete();
        ovf_m = 1'b0;
        bus_if.IOR = 1'b1;
        tick(2);
        reset = 1'b1;
        tick(2);
        read_begin(16'h0227, rb_m[7]);
        read_end();

        // Simultaneous IOR and IOW: write wins
        man_ready = 1'b1;
        seen = 1'b0;
        bus_if.address_bus = 16'h0221;
        bus_if.data_bus_in = 16'h5AA5;
        bus_if.IOW = 1'b0;
        bus_if.IOR = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            seen = seen | bus_if.data_bus_oe;
        end
        bus_if.IOW = 1'b1;
        bus_if.IOR = 1'b1;
        q.push_back('{port: 4'h1, data: 16'h5AA5});
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            seen = seen | bus_if.data_bus_oe;
        end
        check("both_oe", 32'(seen), 32'd0);
        wait_drain();
        man_ready = 1'b0;

        // Randomized traffic against the model
        auto_ready = 1'b1;
        for (int it = 0; it < 40; it++) begin
            p = 4'($urandom_range(0, 15));
            d = 16'($urandom);
            case ($urandom_range(0, 3))
                0: bus_write(16'h0220 | 16'(p), d, int'($urandom_range(3, 6)), 1'b0, 1'b0);
                1: begin
                    read_begin(16'h0220 | 16'(p), rb_m[p]);
                    tick(int'($urandom_range(0, 3)));
                    read_end();
                end
                2: begin
                    a = 16'($urandom);
                    if (in_win(a)) a = a ^ 16'h8000;
                    if ($urandom_range(0, 1) == 0)
                        bus_write(a, d, 4, 1'b0, 1'b0);
                    else
                        oow_read(a);
                end
                default: rb_write(p, d);
            endcase
        end
        wait_drain();
        check("rand_overflow", 32'(bus_if.overflow), 32'(ovf_m));
        auto_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/isa_io_target.md
Name: isa_io_target

Overview:
- ISA I/O-port responder: the target side of the same IOR/IOW bus cycles that the HPS-side bus master generates.
- Decodes a 2^WINDOW_BITS-port window at BASE_ADDR.
- Bus writes are captured into a FIFO that the HPS drains over a valid/ready handshake.
- Bus reads return words from a readback register file that the HPS loads.
- Sits between the riser's ISA pins (top level builds the tri-state) and the HPS bridge.

Parameters:
- BASE_ADDR, 16'h0220, window base; low WINDOW_BITS bits are ignored.
- WINDOW_BITS, 4, port-index width; window size is 2^WINDOW_BITS ports.
- FIFO_DEPTH_LOG2, 3, write FIFO holds 2^FIFO_DEPTH_LOG2 entries.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- address_bus  in  16  ISA I/O address.
- data_bus_in  in  16  ISA data from the pins.
- IOW  in  1  ISA write strobe, active-low, asynchronous.
- IOR  in  1  ISA read strobe, active-low, asynchronous.
- data_bus_out  out  16  read data toward the pins.
- data_bus_oe  out  1  high = top level drives data_bus_out onto the pins.
- wr_valid  out  1  FIFO head valid.
- wr_ready  in  1  HPS accepts the head.
- wr_port  out  WINDOW_BITS  port index of the head entry.
- wr_data  out  16  data of the head entry.
- rb_we  in  1  readback register write enable.
- rb_addr  in  WINDOW_BITS  readback register index.
- rb_data  in  16  readback register write data.
- rd_strobe  out  1  one-cycle pulse at the start of each decoded read.
- rd_port  out  WINDOW_BITS  port of the last decoded read; held until the next read.
- overflow  out  1  sticky: a bus write was dropped because the FIFO was full.
- overflow_clear  in  1  clears overflow.

Behaviour:
- Reset (reset low, async): all outputs 0, FSM=IDLE, FIFO empty, readback registers 0, synchronizers loaded with 1 (strobes deasserted).
- Synchronization: IOW and IOR each pass through 2 flops (iow_s, ior_s). address_bus is sampled only in the cycle the FSM leaves IDLE. data_bus_in is registered every cycle while in WRITE.
- hit = address_bus[15:WINDOW_BITS] == BASE_ADDR[15:WINDOW_BITS].
- FSM IDLE:
  - iow_s==0 && hit → WRITE; latch port = address_bus[WINDOW_BITS-1:0].
  - else ior_s==0 && hit → READ; latch port; snapshot readback[port] into data_bus_out; assert rd_strobe for one cycle; rd_port <= port.
  - Both strobes low with hit → WRITE (write has priority).
  - No hit → stay IDLE; outputs unchanged.
- FSM WRITE: data register follows data_bus_in. On iow_s==1 → push {port, data register} and go to IDLE.
- FSM READ: data_bus_oe=1 from the first READ cycle. Stays in READ while ior_s==0. On ior_s==1: data_bus_oe=0 in that same registered update, then IDLE.
- data_bus_out holds the snapshot for the whole read. An rb_we to the same index during READ updates the register but not the bus value.
- Latency:
  - IOR pin low → data_bus_oe high 3 clk edges later (2 sync + 1 FSM).
  - IOW pin high → wr_valid high 4 clk edges later (2 sync + push + FIFO output register), when the FIFO was empty.
- FIFO:
  - First-word-fall-through; wr_port/wr_data are valid whenever wr_valid=1.
  - Pop when wr_valid && wr_ready.
  - Push while full with a pop in the same cycle is accepted.
  - Push while full without a pop: entry dropped, overflow <= 1.
  - overflow_clear and a new overflow in the same cycle: set wins.
  - Read/write pointers wrap modulo depth; full/empty are distinguished by an extra pointer bit.
- Readback registers: write on rb_we at the clk edge, independent of FSM state.
- Reset mid-cycle: bus cycle abandoned, data_bus_oe drops immediately (async), no FIFO push.
- Out-of-window accesses never drive the bus and never push.

Test Plan:
- Write flow: rb_we idle; bus write 16'hA55A to 0x022C (IOW low 6 clk) → wr_valid high 4 clk after IOW rises; wr_port=4'hC, wr_data=16'hA55A; wr_ready=1 → wr_valid=0 next cycle.
- Readback flow: rb_we rb_addr=3 rb_data=16'h1234; bus read 0x0223 → data_bus_oe=1 with data_bus_out=16'h1234 3 clk after IOR falls; rd_strobe one pulse, rd_port=3; oe=0 3 clk after IOR rises.
- Out of window: read at 0x0230 and write at 0x0210 → data_bus_oe stays 0, FIFO empty, rd_strobe never pulses.
- FIFO full: 9 writes with wr_ready=0 (values 1..9) → 8 entries drained in order 1..8, value 9 dropped, overflow=1; overflow_clear → 0; 8 further writes with a pop each cycle while full → no overflow.
- Snapshot: during a read of port 5 (value 16'h00FF), rb_we port 5 = 16'hBEEF → bus stays 16'h00FF; the next read returns 16'hBEEF.
- Reset mid-read and simultaneous IOR/IOW: reset low while oe=1 → oe=0 immediately, outputs 0. Both strobes low at 0x0221 → treated as a write, one FIFO entry, oe stays 0.
